writeback_queue: RTL and testbench

- Small in-order FIFO of pending register writes.
- Sits between the functional-unit result path and the register file write port. It accepts results, then drains one per cycle into write_enable / write_index / register_write_data.
- The register file gives host writes priority, so a datapath write presented during a host write would be lost. This block holds the head entry whenever the host is writing.
- Provides youngest-match forwarding for the three operand read indices, so un-drained results are visible to readers.

---
 rtl/writeback_queue_pkg.sv | 18 +
 rtl/writeback_bypass_lookup.sv | 46 ++++
 rtl/writeback_queue.sv | 135 +++++++++++++
 tb/tb_writeback_queue.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_queue_pkg.sv
// -----------------------------------------------------------------------------
// writeback_queue_pkg
// Shared datapath types for the writeback queue and its bypass lookup.
//   TIA_REGISTER_INDEX_WIDTH : width of a register-file index
//   TIA_WORD_WIDTH           : width of a register-file data word
//   writeback_entry_t        : one pending register write (index + data)
// -----------------------------------------------------------------------------
package writeback_queue_pkg;

  localparam int TIA_REGISTER_INDEX_WIDTH = 5;
  localparam int TIA_WORD_WIDTH           = 32;

  typedef struct packed {
    logic [TIA_REGISTER_INDEX_WIDTH-1:0] index;
    logic [TIA_WORD_WIDTH-1:0]           data;
  } writeback_entry_t;

endpackage : writeback_queue_pkg

// File: rtl/writeback_bypass_lookup.sv
// -----------------------------------------------------------------------------
// writeback_bypass_lookup
// Youngest-match search over the pending entries of the writeback queue for a
// single read port.
//   entries_i    : queue storage, indexed by physical slot
//   valid_i      : per-slot occupancy mask
//   head_ptr_i   : slot holding the oldest pending entry
//   read_index_i : register index being read
//   hit_o        : some valid entry targets read_index_i
//   data_o       : data of the youngest such entry, 0 when no hit
// -----------------------------------------------------------------------------
module writeback_bypass_lookup
  import writeback_queue_pkg::*;
#(
  parameter  int DEPTH     = 4,
  localparam int PTR_WIDTH = $clog2(DEPTH)
) (
  input  writeback_entry_t                    entries_i [DEPTH],
  input  logic [DEPTH-1:0]                    valid_i,
  input  logic [PTR_WIDTH-1:0]                head_ptr_i,
  input  logic [TIA_REGISTER_INDEX_WIDTH-1:0] read_index_i,
  output logic                                hit_o,
  output logic [TIA_WORD_WIDTH-1:0]           data_o
);

  logic [PTR_WIDTH-1:0] slot;

  // Walk from the oldest entry to the youngest and let each later match
  // overwrite the earlier one; the surviving value is the youngest match,
  // which is the same priority as searching from the tail backwards.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the loop can leave a value unassigned and infer a latch.
    hit_o  = 1'b0;
    data_o = '0;
    slot   = head_ptr_i;
    for (int age = 0; age < DEPTH; age++) begin
      slot = head_ptr_i + PTR_WIDTH'(age);
      if (valid_i[slot] && (entries_i[slot].index == read_index_i)) begin
        hit_o  = 1'b1;
        data_o = entries_i[slot].data;
      end
    end
  end

endmodule : writeback_bypass_lookup

// File: rtl/writeback_queue.sv
// -----------------------------------------------------------------------------
// writeback_queue
// In-order FIFO of pending register writes between the functional-unit result
// path and the register-file write port. Drains one entry per cycle, holds the
// head while the host owns the write port, and forwards the youngest pending
// value for each of three operand read indices.
//   clock, reset           : clock, synchronous active-low reset
//   enable                 : stage enable shared with the register file
//   host_write_req         : host is writing the register file this cycle
//   push/push_index/_data  : incoming result; push_ready acknowledges it
//   write_enable/_index,
//   register_write_data    : register-file write port
//   read_index_0..2        : operand indices; bypass_hit/_data_0..2 forward
//   pending_count, empty   : occupancy
// -----------------------------------------------------------------------------
module writeback_queue
  import writeback_queue_pkg::*;
#(
  parameter  int DEPTH       = 4,
  localparam int COUNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                enable,
  input  logic                                host_write_req,
  input  logic                                push,
  input  logic [TIA_REGISTER_INDEX_WIDTH-1:0] push_index,
  input  logic [TIA_WORD_WIDTH-1:0]           push_data,
  output logic                                push_ready,
  output logic                                write_enable,
  output logic [TIA_REGISTER_INDEX_WIDTH-1:0] write_index,
  output logic [TIA_WORD_WIDTH-1:0]           register_write_data,
  input  logic [TIA_REGISTER_INDEX_WIDTH-1:0] read_index_0,
  input  logic [TIA_REGISTER_INDEX_WIDTH-1:0] read_index_1,
  input  logic [TIA_REGISTER_INDEX_WIDTH-1:0] read_index_2,
  output logic                                bypass_hit_0,
  output logic                                bypass_hit_1,
  output logic                                bypass_hit_2,
  output logic [TIA_WORD_WIDTH-1:0]           bypass_data_0,
  output logic [TIA_WORD_WIDTH-1:0]           bypass_data_1,
  output logic [TIA_WORD_WIDTH-1:0]           bypass_data_2,
  output logic [COUNT_WIDTH-1:0]              pending_count,
  output logic                                empty
);

  localparam int PTR_WIDTH = $clog2(DEPTH);

  writeback_entry_t       entries_q [DEPTH];
  logic [PTR_WIDTH-1:0]   head_q, head_d;
  logic [PTR_WIDTH-1:0]   tail_q, tail_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  logic                   full;
  logic                   pop;
  logic                   do_push;
  logic [DEPTH-1:0]       valid;
  logic [PTR_WIDTH-1:0]   offset;

  assign empty         = (count_q == '0);
  assign full          = (count_q == COUNT_WIDTH'(DEPTH));
  assign pending_count = count_q;

  // Gating with reset keeps a reset cycle from issuing a stale write while
  // the queue is being discarded.
  assign write_enable = reset && !empty && enable && !host_write_req;
  assign pop          = write_enable;
  assign push_ready   = enable && (!full || pop);
  assign do_push      = push && push_ready;

  assign write_index         = empty ? '0 : entries_q[head_q].index;
  assign register_write_data = empty ? '0 : entries_q[head_q].data;

  // A slot is occupied when its distance from the head is below the count.
  always_comb begin
    valid  = '0;
    offset = '0;
    for (int s = 0; s < DEPTH; s++) begin
      offset   = PTR_WIDTH'(s) - head_q;
      valid[s] = (COUNT_WIDTH'(offset) < count_q);
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (do_push) tail_d = tail_q + PTR_WIDTH'(1);
    if (pop)     head_d = head_q + PTR_WIDTH'(1);
    case ({do_push, pop})
      2'b10:   count_d = count_q + COUNT_WIDTH'(1);
      2'b01:   count_d = count_q - COUNT_WIDTH'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: payload storage is deliberately left out of reset; the pointers and
  // count decide what is valid, so clearing the array would only cost logic.
  always_ff @(posedge clock) begin
    if (reset && do_push) begin
      entries_q[tail_q] <= '{index: push_index, data: push_data};
    end
  end

  // The bypass sees only registered entries, so a same-cycle push never
  // reaches bypass_data combinationally.
  writeback_bypass_lookup #(.DEPTH(DEPTH)) u_lookup_0 (
    .entries_i(entries_q), .valid_i(valid), .head_ptr_i(head_q),
    .read_index_i(read_index_0), .hit_o(bypass_hit_0), .data_o(bypass_data_0)
  );

  writeback_bypass_lookup #(.DEPTH(DEPTH)) u_lookup_1 (
    .entries_i(entries_q), .valid_i(valid), .head_ptr_i(head_q),
    .read_index_i(read_index_1), .hit_o(bypass_hit_1), .data_o(bypass_data_1)
  );

  writeback_bypass_lookup #(.DEPTH(DEPTH)) u_lookup_2 (
    .entries_i(entries_q), .valid_i(valid), .head_ptr_i(head_q),
    .read_index_i(read_index_2), .hit_o(bypass_hit_2), .data_o(bypass_data_2)
  );

endmodule : writeback_queue

// File: tb/tb_writeback_queue.sv
// -----------------------------------------------------------------------------
// tb_writeback_queue
// Directed bench for writeback_queue (DEPTH=4). Inputs change 1 ns after each
// rising edge; outputs are sampled 1 ns after that, well away from the edge.
// A small register-file model records every issued write.
// -----------------------------------------------------------------------------
module tb_writeback_queue;
  import writeback_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic                                clock = 1'b0;
  logic                                reset;
  logic                                enable;
  logic                                host_write_req;
  logic                                push;
  logic [TIA_REGISTER_INDEX_WIDTH-1:0] push_index;
  logic [TIA_WORD_WIDTH-1:0]           push_data;
  logic                                push_ready;
  logic                                write_enable;
  logic [TIA_REGISTER_INDEX_WIDTH-1:0] write_index;
  logic [TIA_WORD_WIDTH-1:0]           register_write_data;
  logic [TIA_REGISTER_INDEX_WIDTH-1:0] read_index_0, read_index_1, read_index_2;
  logic                                bypass_hit_0, bypass_hit_1, bypass_hit_2;
  logic [TIA_WORD_WIDTH-1:0]           bypass_data_0, bypass_data_1, bypass_data_2;
  logic [CW-1:0]                       pending_count;
  logic                                empty;

  int total = 0;
  int bad   = 0;

  logic [TIA_WORD_WIDTH-1:0] regfile [32];

  always #5 clock = ~clock;

  writeback_queue #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .host_write_req(host_write_req), .push(push), .push_index(push_index),
    .push_data(push_data), .push_ready(push_ready),
    .write_enable(write_enable), .write_index(write_index),
    .register_write_data(register_write_data),
    .read_index_0(read_index_0), .read_index_1(read_index_1),
    .read_index_2(read_index_2),
    .bypass_hit_0(bypass_hit_0), .bypass_hit_1(bypass_hit_1),
    .bypass_hit_2(bypass_hit_2),
    .bypass_data_0(bypass_data_0), .bypass_data_1(bypass_data_1),
    .bypass_data_2(bypass_data_2),
    .pending_count(pending_count), .empty(empty)
  );

  // Register-file model: host writes are never driven here, so every
  // write_enable at an edge lands.
  always @(posedge clock) begin
    if (write_enable) regfile[write_index] <= register_write_data;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Pushes one entry while host_write_req holds the head.
  task automatic stalled_push(input int idx, input int data);
    host_write_req = 1'b1;
    push       = 1'b1;
    push_index = TIA_REGISTER_INDEX_WIDTH'(idx);
    push_data  = TIA_WORD_WIDTH'(data);
    tick();
    push = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b1; host_write_req = 1'b0; push = 1'b0;
    push_index = '0; push_data = '0;
    read_index_0 = 5'd3; read_index_1 = 5'd0; read_index_2 = 5'd7;
    tick();
    reset = 1'b1;
    settle();
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%0b want=1", empty); end
    total++; if (pending_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", pending_count); end
    total++; if (write_enable !== 1'b0) begin bad++; $display("FAIL reset_we got=%0b want=0", write_enable); end
    total++; if ({bypass_hit_0, bypass_hit_1, bypass_hit_2} !== 3'b000) begin bad++; $display("FAIL reset_hits got=%03b want=000", {bypass_hit_0, bypass_hit_1, bypass_hit_2}); end
    total++; if (bypass_data_0 !== 32'h0 || bypass_data_1 !== 32'h0 || bypass_data_2 !== 32'h0) begin bad++; $display("FAIL reset_bdata got=%0h/%0h/%0h want=0", bypass_data_0, bypass_data_1, bypass_data_2); end
    total++; if (push_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b want=1", push_ready); end
    total++; if (write_index !== 5'd0 || register_write_data !== 32'h0) begin bad++; $display("FAIL reset_head got=%0d/%0h want=0/0", write_index, register_write_data); end
  endtask

  task automatic test_single_push();
    push = 1'b1; push_index = 5'd3; push_data = 32'hAA; read_index_0 = 5'd3;
    settle();
    total++; if (push_ready !== 1'b1) begin bad++; $display("FAIL single_ready got=%0b want=1", push_ready); end
    total++; if (bypass_hit_0 !== 1'b0) begin bad++; $display("FAIL single_nobypass_same_cycle got=%0b want=0", bypass_hit_0); end
    total++; if (write_enable !== 1'b0) begin bad++; $display("FAIL single_we_n got=%0b want=0", write_enable); end
    tick();
    push = 1'b0;
    settle();
    total++; if (write_enable !== 1'b1) begin bad++; $display("FAIL single_we got=%0b want=1", write_enable); end
    total++; if (write_index !== 5'd3 || register_write_data !== 32'hAA) begin bad++; $display("FAIL single_write got=%0d/%0h want=3/aa", write_index, register_write_data); end
    total++; if (bypass_hit_0 !== 1'b1 || bypass_data_0 !== 32'hAA) begin bad++; $display("FAIL single_bypass got=%0b/%0h want=1/aa", bypass_hit_0, bypass_data_0); end
    tick();
    total++; if (empty !== 1'b1 || write_enable !== 1'b0) begin bad++; $display("FAIL single_drained got empty=%0b we=%0b want 1/0", empty, write_enable); end
    total++; if (regfile[3] !== 32'hAA) begin bad++; $display("FAIL single_regfile got=%0h want=aa", regfile[3]); end
  endtask

  task automatic test_host_stall();
    host_write_req = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      push = 1'b1; push_index = 5'(i); push_data = 32'h10 + 32'(i);
      settle();
      total++; if (push_ready !== 1'b1) begin bad++; $display("FAIL stall_ready_%0d got=%0b want=1", i, push_ready); end
      tick();
    end
    push_index = 5'd9; push_data = 32'h99; read_index_1 = 5'd2;
    settle();
    total++; if (push_ready !== 1'b0) begin bad++; $display("FAIL stall_full_ready got=%0b want=0", push_ready); end
    total++; if (pending_count !== 3'd4 || write_enable !== 1'b0) begin bad++; $display("FAIL stall_full got cnt=%0d we=%0b want 4/0", pending_count, write_enable); end
    total++; if (bypass_hit_1 !== 1'b1 || bypass_data_1 !== 32'h12) begin bad++; $display("FAIL stall_bypass got=%0b/%0h want=1/12", bypass_hit_1, bypass_data_1); end
    push = 1'b0; host_write_req = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      settle();
      total++; if (write_enable !== 1'b1 || write_index !== 5'(i) || register_write_data !== 32'h10 + 32'(i)) begin bad++; $display("FAIL stall_drain_%0d got we=%0b idx=%0d data=%0h want 1/%0d/%0h", i, write_enable, write_index, register_write_data, i, 32'h10 + 32'(i)); end
      tick();
    end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL stall_empty got=%0b want=1", empty); end
  endtask

  task automatic test_full_push_pop();
    for (int i = 1; i <= 4; i++) stalled_push(i, 32'h20 + i);
    host_write_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      push = 1'b1; push_index = 5'(6 + c); push_data = 32'h30 + 32'(c);
      settle();
      total++; if (push_ready !== 1'b1 || write_enable !== 1'b1) begin bad++; $display("FAIL full_pp_hs_%0d got ready=%0b we=%0b want 1/1", c, push_ready, write_enable); end
      total++; if (write_index !== 5'(1 + c) || pending_count !== 3'd4) begin bad++; $display("FAIL full_pp_%0d got idx=%0d cnt=%0d want %0d/4", c, write_index, pending_count, 1 + c); end
      tick();
    end
    push = 1'b0;
    begin
      logic [4:0]  exp_idx  [4];
      logic [31:0] exp_data [4];
      exp_idx  = '{5'd4, 5'd6, 5'd7, 5'd8};
      exp_data = '{32'h24, 32'h30, 32'h31, 32'h32};
      for (int k = 0; k < 4; k++) begin
        settle();
        total++; if (write_index !== exp_idx[k] || register_write_data !== exp_data[k] || pending_count !== 3'(4 - k)) begin bad++; $display("FAIL full_order_%0d got idx=%0d data=%0h cnt=%0d want %0d/%0h/%0d", k, write_index, register_write_data, pending_count, exp_idx[k], exp_data[k], 4 - k); end
        tick();
      end
    end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL full_empty got=%0b want=1", empty); end
  endtask

  task automatic test_duplicate();
    stalled_push(5, 32'h11);
    stalled_push(5, 32'h22);
    read_index_1 = 5'd5;
    settle();
    total++; if (bypass_hit_1 !== 1'b1 || bypass_data_1 !== 32'h22) begin bad++; $display("FAIL dup_bypass got=%0b/%0h want=1/22", bypass_hit_1, bypass_data_1); end
    total++; if (pending_count !== 3'd2) begin bad++; $display("FAIL dup_count got=%0d want=2", pending_count); end
    host_write_req = 1'b0;
    settle();
    total++; if (register_write_data !== 32'h11 || bypass_data_1 !== 32'h22) begin bad++; $display("FAIL dup_first got wd=%0h bd=%0h want 11/22", register_write_data, bypass_data_1); end
    tick();
    total++; if (register_write_data !== 32'h22 || bypass_data_1 !== 32'h22) begin bad++; $display("FAIL dup_second got wd=%0h bd=%0h want 22/22", register_write_data, bypass_data_1); end
    tick();
    total++; if (regfile[5] !== 32'h22 || empty !== 1'b1) begin bad++; $display("FAIL dup_final got reg5=%0h empty=%0b want 22/1", regfile[5], empty); end
  endtask

  task automatic test_reset_mid_drain();
    stalled_push(7, 32'h70);
    stalled_push(8, 32'h80);
    stalled_push(9, 32'h90);
    read_index_0 = 5'd7; read_index_1 = 5'd8; read_index_2 = 5'd9;
    host_write_req = 1'b0;
    reset = 1'b0;
    settle();
    total++; if (write_enable !== 1'b0) begin bad++; $display("FAIL rstmid_we got=%0b want=0", write_enable); end
    tick();
    reset = 1'b1;
    settle();
    total++; if (empty !== 1'b1 || pending_count !== 3'd0) begin bad++; $display("FAIL rstmid_empty got empty=%0b cnt=%0d want 1/0", empty, pending_count); end
    total++; if ({bypass_hit_0, bypass_hit_1, bypass_hit_2} !== 3'b000) begin bad++; $display("FAIL rstmid_hits got=%03b want=000", {bypass_hit_0, bypass_hit_1, bypass_hit_2}); end
    total++; if (regfile[7] === 32'h70) begin bad++; $display("FAIL rstmid_nowrite got reg7=%0h want not 70", regfile[7]); end
  endtask

  task automatic test_freeze();
    stalled_push(10, 32'h40);
    stalled_push(11, 32'h41);
    host_write_req = 1'b0; enable = 1'b0;
    push = 1'b1; push_index = 5'd12; push_data = 32'h42;
    settle();
    total++; if (push_ready !== 1'b0 || write_enable !== 1'b0) begin bad++; $display("FAIL freeze_hs got ready=%0b we=%0b want 0/0", push_ready, write_enable); end
    tick();
    tick();
    total++; if (pending_count !== 3'd2) begin bad++; $display("FAIL freeze_count got=%0d want=2", pending_count); end
    enable = 1'b1;
    settle();
    total++; if (push_ready !== 1'b1 || write_enable !== 1'b1 || write_index !== 5'd10) begin bad++; $display("FAIL resume_first got ready=%0b we=%0b idx=%0d want 1/1/10", push_ready, write_enable, write_index); end
    tick();
    push = 1'b0;
    settle();
    total++; if (pending_count !== 3'd2 || write_index !== 5'd11) begin bad++; $display("FAIL resume_second got cnt=%0d idx=%0d want 2/11", pending_count, write_index); end
    tick();
    total++; if (write_index !== 5'd12 || register_write_data !== 32'h42) begin bad++; $display("FAIL resume_third got idx=%0d data=%0h want 12/42", write_index, register_write_data); end
    tick();
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL resume_empty got=%0b want=1", empty); end
  endtask

  initial begin
    for (int r = 0; r < 32; r++) regfile[r] = '0;
    test_reset();
    test_single_push();
    test_host_stall();
    test_full_push_pop();
    test_duplicate();
    test_reset_mid_drain();
    test_freeze();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_writeback_queue
